// File: rtl/branch_predictor_pkg.sv
// Shared Y86 constants for the branch predictor: instruction codes and jump conditions.
// Pure declarations; no timing.
package branch_predictor_pkg;

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } jmpFun_t;

  function automatic logic isUncondJump(input logic [3:0] icode, input logic [3:0] ifun);
    return (icode == IJXX) && (ifun == C_YES);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute resolution signals of the branch predictor.
// master drives fetch/execute inputs; slave is the predictor.
interface branch_predictor_if #(
  parameter int CNT_W = 32
);
  logic [63:0]      f_PC_i;
  logic [3:0]       f_icode_i;
  logic [3:0]       f_ifun_i;
  logic [63:0]      f_valC_i;
  logic [63:0]      f_valP_i;
  logic             f_pred_taken_o;
  logic [63:0]      f_predPC_o;
  logic             upd_valid_i;
  logic [63:0]      E_PC_i;
  logic [3:0]       E_ifun_i;
  logic             e_Cnd_i;
  logic             E_pred_taken_i;
  logic             mispredict_o;
  logic [CNT_W-1:0] branch_count_o;
  logic [CNT_W-1:0] mis_count_o;

  modport master (
    output f_PC_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
    output upd_valid_i, E_PC_i, E_ifun_i, e_Cnd_i, E_pred_taken_i,
    input  f_pred_taken_o, f_predPC_o, mispredict_o, branch_count_o, mis_count_o
  );

  modport slave (
    input  f_PC_i, f_icode_i, f_ifun_i, f_valC_i, f_valP_i,
    input  upd_valid_i, E_PC_i, E_ifun_i, e_Cnd_i, E_pred_taken_i,
    output f_pred_taken_o, f_predPC_o, mispredict_o, branch_count_o, mis_count_o
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Up/down saturating counter with parameterised async reset value.
// Update visible one cycle after an enabled edge; no backpressure.
module sat_counter #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= RST_VAL;
    end else if (en) begin
      if (inc) begin
        if (cnt != {WIDTH{1'b1}}) cnt <= cnt + 1'b1;
      end else begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Jump predictor: PC-indexed table of saturating counters plus statistics.
// Prediction is combinational (0 cycles); table update visible next cycle; never stalls.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int CNT_W    = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [CTR_BITS-1:0] ctr [ENTRIES];
  logic [IDX_W-1:0]    lookIdx;
  logic [IDX_W-1:0]    updIdx;
  logic                tableTaken;
  logic                predTaken;
  logic                tableUpd;
  logic                mispredict;
  logic [CNT_W-1:0]    branchCnt;
  logic [CNT_W-1:0]    misCnt;

  assign lookIdx  = bp.f_PC_i[IDX_W-1:0];
  assign updIdx   = bp.E_PC_i[IDX_W-1:0];
  assign tableUpd = (MODE == 1) && bp.upd_valid_i && (bp.E_ifun_i != C_YES);

  genvar i;
  generate
    for (i = 0; i < ENTRIES; i++) begin : gEntry
      sat_counter #(
        .WIDTH   (CTR_BITS),
        .RST_VAL (CTR_INIT)
      ) uCtr (
        .clk  (clk_i),
        .rstN (rst_n_i),
        .en   (tableUpd && (updIdx == IDX_W'(i))),
        .inc  (bp.e_Cnd_i),
        .cnt  (ctr[i])
      );
    end
  endgenerate

  // Lookup reads the registered counter, so a same-cycle update is not bypassed.
  always_comb begin
    tableTaken = 1'b1;
    if (MODE == 1) tableTaken = ctr[lookIdx][CTR_BITS-1];
  end

  always_comb begin
    predTaken     = 1'b0;
    bp.f_predPC_o = bp.f_valP_i;
    if (bp.f_icode_i == IJXX) begin
      predTaken = isUncondJump(bp.f_icode_i, bp.f_ifun_i) || tableTaken;
      if (predTaken) bp.f_predPC_o = bp.f_valC_i;
    end else if (bp.f_icode_i == ICALL) begin
      bp.f_predPC_o = bp.f_valC_i;
    end
  end

  assign bp.f_pred_taken_o = predTaken;

  assign mispredict = bp.upd_valid_i && (bp.E_ifun_i != C_YES)
                   && (bp.e_Cnd_i != bp.E_pred_taken_i);
  assign bp.mispredict_o = mispredict;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      branchCnt <= '0;
      misCnt    <= '0;
    end else begin
      if (bp.upd_valid_i && (branchCnt != {CNT_W{1'b1}})) branchCnt <= branchCnt + 1'b1;
      if (mispredict && (misCnt != {CNT_W{1'b1}}))        misCnt    <= misCnt + 1'b1;
    end
  end

  assign bp.branch_count_o = branchCnt;
  assign bp.mis_count_o    = misCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: dynamic (MODE 1) and static 4-bit-stat (MODE 0) instances
// driven in lockstep and checked every cycle against a behavioural model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [63:0] fPC = '0, fValC = '0, fValP = '0, ePC = '0;
  logic [3:0]  fIcode = '0, fIfun = '0, eIfun = '0;
  logic        updValid = 1'b0, eCnd = 1'b0, ePredTaken = 1'b0;
  bit          checkEn = 1'b0;
  int          total = 0;
  int          bad = 0;

  // model state
  int     tbl [16];
  longint brA, misA, brB, misB;
  localparam longint CAPA = 64'd4294967295;
  localparam longint CAPB = 64'd15;

  always #5 clk = ~clk;

  branch_predictor_if #(.CNT_W(32)) ifA ();
  branch_predictor_if #(.CNT_W(4))  ifB ();

  assign ifA.f_PC_i = fPC;          assign ifB.f_PC_i = fPC;
  assign ifA.f_icode_i = fIcode;    assign ifB.f_icode_i = fIcode;
  assign ifA.f_ifun_i = fIfun;      assign ifB.f_ifun_i = fIfun;
  assign ifA.f_valC_i = fValC;      assign ifB.f_valC_i = fValC;
  assign ifA.f_valP_i = fValP;      assign ifB.f_valP_i = fValP;
  assign ifA.upd_valid_i = updValid; assign ifB.upd_valid_i = updValid;
  assign ifA.E_PC_i = ePC;          assign ifB.E_PC_i = ePC;
  assign ifA.E_ifun_i = eIfun;      assign ifB.E_ifun_i = eIfun;
  assign ifA.e_Cnd_i = eCnd;        assign ifB.e_Cnd_i = eCnd;
  assign ifA.E_pred_taken_i = ePredTaken; assign ifB.E_pred_taken_i = ePredTaken;

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(1), .CNT_W(32)) dutA (
    .clk_i(clk), .rst_n_i(rstN), .bp(ifA.slave));
  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(0), .CNT_W(4)) dutB (
    .clk_i(clk), .rst_n_i(rstN), .bp(ifB.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit expMis();
    return updValid && (eIfun != 0) && (eCnd != ePredTaken);
  endfunction

  function automatic longint satInc(input longint v, input longint cap);
    return (v >= cap) ? cap : v + 1;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 16; k++) tbl[k] = 2;
    brA = 0; misA = 0; brB = 0; misB = 0;
  endfunction

  // Model state advances on the same edges as the DUT; reset is asynchronous.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      modelReset();
    end else if (updValid) begin
      brA = satInc(brA, CAPA);
      brB = satInc(brB, CAPB);
      if (expMis()) begin
        misA = satInc(misA, CAPA);
        misB = satInc(misB, CAPB);
      end
      if (eIfun != 0) begin
        if (eCnd) tbl[ePC % 16] = (tbl[ePC % 16] >= 3) ? 3 : tbl[ePC % 16] + 1;
        else      tbl[ePC % 16] = (tbl[ePC % 16] <= 0) ? 0 : tbl[ePC % 16] - 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit isJ, takeA, takeB;
    logic [63:0] pcA, pcB;
    if (checkEn) begin
      isJ   = (fIcode == 7);
      takeA = isJ && ((fIfun == 0) || (tbl[fPC % 16] >= 2));
      takeB = isJ;
      pcA   = ((fIcode == 8) || takeA) ? fValC : fValP;
      pcB   = ((fIcode == 8) || takeB) ? fValC : fValP;
      chk("A_taken",  64'(ifA.f_pred_taken_o), 64'(takeA));
      chk("A_predPC", ifA.f_predPC_o, pcA);
      chk("A_mis",    64'(ifA.mispredict_o), 64'(expMis()));
      chk("A_brcnt",  64'(ifA.branch_count_o), brA);
      chk("A_miscnt", 64'(ifA.mis_count_o), misA);
      chk("B_taken",  64'(ifB.f_pred_taken_o), 64'(takeB));
      chk("B_predPC", ifB.f_predPC_o, pcB);
      chk("B_mis",    64'(ifB.mispredict_o), 64'(expMis()));
      chk("B_brcnt",  64'(ifB.branch_count_o), brB);
      chk("B_miscnt", 64'(ifB.mis_count_o), misB);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFetch(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                          input logic [63:0] vc, input logic [63:0] vp);
    fPC = pc; fIcode = ic; fIfun = fn; fValC = vc; fValP = vp;
  endtask

  task automatic setUpd(input logic v, input logic [63:0] pc, input logic [3:0] fn,
                        input logic cnd, input logic pred);
    updValid = v; ePC = pc; eIfun = fn; eCnd = cnd; ePredTaken = pred;
  endtask

  initial begin
    modelReset();
    setFetch(64'h10, 4'd7, 4'd1, 64'h40, 64'h19);
    setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #1 rstN = 1'b0;
    #2 checkEn = 1'b1;
    // reset state and jle lookup at 0x10
    chk("rst_taken",  64'(ifA.f_pred_taken_o), 64'd1);
    chk("rst_predPC", ifA.f_predPC_o, 64'h40);
    chk("rst_brcnt",  64'(ifA.branch_count_o), 64'd0);
    chk("rst_miscnt", 64'(ifA.mis_count_o), 64'd0);
    @(posedge clk); #2 rstN = 1'b1;

    // two not-taken updates at 0x10: counter 2 -> 1 -> 0
    tick(); setUpd(1'b1, 64'h10, 4'd1, 1'b0, 1'b1);
    #2 chk("nt1_mis", 64'(ifA.mispredict_o), 64'd1);
    tick(); setUpd(1'b1, 64'h10, 4'd1, 1'b0, 1'b0);
    #2 chk("nt2_mis", 64'(ifA.mispredict_o), 64'd0);
    tick(); setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #2 chk("nt_miscnt", 64'(ifA.mis_count_o), 64'd1);
    chk("nt_taken",  64'(ifA.f_pred_taken_o), 64'd0);
    chk("nt_predPC", ifA.f_predPC_o, 64'h19);

    // five taken updates from 0: 1,2,3,3,3 (predictions carried 0,0,1,1,1)
    for (int k = 0; k < 5; k++) begin
      tick(); setUpd(1'b1, 64'h10, 4'd1, 1'b1, (k >= 2));
    end
    tick(); setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #2 chk("sat_taken", 64'(ifA.f_pred_taken_o), 64'd1);
    chk("sat_brcnt", 64'(ifA.branch_count_o), 64'd7);
    chk("sat_miscnt", 64'(ifA.mis_count_o), 64'd3);

    // 3 -> 2, then same-cycle lookup/update at counter 2
    tick(); setUpd(1'b1, 64'h10, 4'd1, 1'b0, 1'b1);
    tick(); setUpd(1'b1, 64'h10, 4'd1, 1'b0, 1'b1);
    #2 chk("same_cyc_taken", 64'(ifA.f_pred_taken_o), 64'd1);
    tick(); setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #2 chk("next_cyc_taken", 64'(ifA.f_pred_taken_o), 64'd0);
    chk("static_taken", 64'(ifB.f_pred_taken_o), 64'd1);

    // jmp always taken; call goes to valC; others to valP
    setFetch(64'h10, 4'd7, 4'd0, 64'h80, 64'h19);
    #1 chk("jmp_predPC", ifA.f_predPC_o, 64'h80);
    setFetch(64'h20, 4'd8, 4'd0, 64'h100, 64'h29);
    #1 chk("call_predPC", ifA.f_predPC_o, 64'h100);
    chk("call_taken", 64'(ifA.f_pred_taken_o), 64'd0);
    setFetch(64'h30, 4'd6, 4'd1, 64'h200, 64'h32);
    #1 chk("opq_predPC", ifA.f_predPC_o, 64'h32);
    setFetch(64'h10, 4'd7, 4'd1, 64'h40, 64'h19);

    // static instance: 20 not-taken mispredicts saturate 4-bit stats
    for (int k = 0; k < 20; k++) begin
      tick(); setUpd(1'b1, 64'h30, 4'd1, 1'b0, 1'b1);
    end
    tick(); setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #2 chk("B_mis_sat", 64'(ifB.mis_count_o), 64'd15);
    chk("B_br_sat", 64'(ifB.branch_count_o), 64'd15);
    chk("B_still_taken", 64'(ifB.f_pred_taken_o), 64'd1);

    // asynchronous reset mid-cycle
    tick();
    #2 rstN = 1'b0;
    #1 chk("arst_brcnt", 64'(ifA.branch_count_o), 64'd0);
    chk("arst_miscnt", 64'(ifA.mis_count_o), 64'd0);
    chk("arst_B_miscnt", 64'(ifB.mis_count_o), 64'd0);
    chk("arst_taken_0x10", 64'(ifA.f_pred_taken_o), 64'd1);
    @(posedge clk); #2 rstN = 1'b1;
    // one not-taken update per entry: every counter must then sit at 1
    for (int k = 0; k < 16; k++) begin
      tick(); setUpd(1'b1, 64'(k), 4'd2, 1'b0, 1'b1);
    end
    tick(); setUpd(1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      setFetch(64'(k), 4'd7, 4'd3, 64'h40, 64'h19);
      #0.1 chk("arst_entry", 64'(ifA.f_pred_taken_o), 64'd0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] pc;
      int sel;
      tick();
      pc  = (($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 63)));
      sel = $urandom_range(0, 3);
      setFetch(pc, (sel < 2) ? 4'd7 : (sel == 2) ? 4'd8 : 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 6)), {$urandom, $urandom}, {$urandom, $urandom});
      setUpd(1'($urandom_range(0, 1)), 64'($urandom_range(0, 31)), 4'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 499) == 0) begin
        #1 rstN = 1'b0;
        #1 rstN = 1'b1;
      end
    end

    tick();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
